// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Latency: none, definitions only.
// Backpressure: not applicable.
package fetch_pkg;

    // Fetch sequencer states: one boot cycle, then alternate request / wait.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_e;

    // Sequential fetch stride in bytes.
    localparam int unsigned PC_STEP = 4;

    // First fetch address; the PC register's reset value plus one step wraps here.
    localparam logic [31:0] BOOT_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_inst_buf.sv
// Single-entry instruction buffer between fetch and decode.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds its entry while out_valid && !drain; flush beats load beats drain.
module inst_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [INST_W-1:0] load_inst,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              drain,
    input  logic              flush,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
);

    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Next entry: a flush kills the entry, a reload overrides a same-cycle drain.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc_d    = load_pc;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers; data is kept after drain/flush, only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: drives next-PC, issues one imem request at a time, buffers the word for decode.
// Latency: request at t, response >= t+1, inst_valid >= t+2; peak one instruction per 2 cycles.
// Backpressure: no request while the buffer is full and not draining; responses are never stalled.
// Optional IF_FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module if_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              req_hs;
    logic              buf_load;
    logic              buf_flush;
    logic              buf_drain;

    assign pc_inc        = pc + ADDR_W'(PC_STEP);
    assign imem_req_addr = pc;
    assign buf_drain     = inst_valid && inst_ready;

    // Sequencer next state, next PC and request strobe; a redirect overrides everything outside BOOT.
    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        req_pc_d       = req_pc_q;
        npc            = pc;
        imem_req_valid = 1'b0;
        req_hs         = 1'b0;
        buf_load       = 1'b0;
        buf_flush      = 1'b0;

        case (state_q)
            BOOT: begin
                npc     = pc_inc;
                state_d = FETCH;
            end
            FETCH: begin
                // Only ask when the buffer will be free by the time the word returns.
                imem_req_valid = !inst_valid || inst_ready;
                if (imem_req_valid && imem_req_ready) begin
                    req_hs   = 1'b1;
                    npc      = pc_inc;
                    req_pc_d = pc;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        buf_load = 1'b1;
                    end
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (redirect_valid && (state_q != BOOT)) begin
            npc       = redirect_pc;
            buf_flush = 1'b1;
            // A request still owed by memory must have its response swallowed.
            if (((state_q == WAIT) && !imem_resp_valid) || req_hs) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else begin
                state_d = FETCH;
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            drop_q   <= 1'b0;
            req_pc_q <= ADDR_W'(BOOT_PC);
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            req_pc_q <= req_pc_d;
        end
    end

    inst_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_inst (imem_resp_data),
        .load_pc   (req_pc_q),
        .drain     (buf_drain),
        .flush     (buf_flush),
        .out_valid (inst_valid),
        .out_inst  (inst),
        .out_pc    (inst_pc)
    );

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count delivered (non-dropped) responses and FETCH cycles blocked by memory.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == WAIT) && imem_resp_valid && !drop_q) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == FETCH) && imem_req_valid && !imem_req_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: PC register and instruction memory live here; a monitor scoreboards decode output.
// Latency: n/a.
// Backpressure: memory ready and decode ready are randomized or forced per scenario.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc, npc, imem_req_addr, imem_resp_data, inst, inst_pc, redirect_pc;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        inst_valid, inst_ready, redirect_valid;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
    logic [31:0] stall_snap;
`endif

    if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .npc             (npc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Driver knobs and memory model state.
    int          rdy_pct, ir_pct, redir_pct, lat_min, lat_max;
    int          since_rst;
    bit          mem_pending;
    int          mem_wait;
    logic [31:0] mem_addr;

    // Written by the monitor at each falling edge, read by the driver.
    logic [31:0] npc_lat;
    bit          hs_seen;
    logic [31:0] hs_addr;
    int          consumed;

    // Reference model: address decode must receive next.
    logic [31:0] exp_q[$];

    logic [31:0] a_npc [5];
    logic [31:0] a_iv  [5];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a + 32'h0000_000B;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // One clock: load PC register, advance memory, then drive randomized inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        pc = rst ? 32'hFFFF_FFFC : npc_lat;
        if (rst) begin
            since_rst   = 0;
            mem_pending = 0;
        end else begin
            since_rst++;
        end
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (hs_seen && !rst) begin
            mem_pending = 1;
            mem_addr    = hs_addr;
            mem_wait    = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        if (mem_pending) begin
            if (mem_wait == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word(mem_addr);
                mem_pending     = 0;
            end else begin
                mem_wait--;
            end
        end
        imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
        inst_ready     = (int'($urandom_range(99)) < ir_pct);
        redirect_valid = 1'b0;
        if (since_rst >= 2 && int'($urandom_range(99)) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
        end
    endtask

    // Reset for three cycles; returns at the start of the BOOT cycle.
    task automatic do_reset();
        rst = 1'b1;
        pc  = 32'hFFFF_FFFC;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        mem_pending     = 0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Monitor: protocol rules every cycle and scoreboard on every decode handshake.
    bit          prev_rst = 1'b1;
    bit          prev_hold = 1'b0;
    bit          prev_redir = 1'b0;
    logic [31:0] prev_inst, prev_ipc;
    initial begin : monitor
        bit          boot_now;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            boot_now = !rst && prev_rst;
            chk("req_addr_eq_pc", imem_req_addr, pc);
            if (rst || boot_now) begin
                chk("boot_npc", npc, pc + 32'd4);
                chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
                chk("boot_inst_valid", 32'(inst_valid), 32'd0);
            end
            if (rst) begin
                chk("rst_inst", inst, 32'd0);
                chk("rst_inst_pc", inst_pc, 32'd0);
                exp_q.delete();
                exp_q.push_back(32'h0);
            end else begin
                if (!boot_now) begin
                    if (redirect_valid)
                        chk("npc_redirect", npc, redirect_pc);
                    else if (imem_req_valid && imem_req_ready)
                        chk("npc_step", npc, pc + 32'd4);
                    else
                        chk("npc_hold", npc, pc);
                    if (imem_req_valid) begin
                        chk("one_in_flight", 32'(mem_pending || imem_resp_valid), 32'd0);
                        chk("req_buf_free", 32'(inst_valid && !inst_ready), 32'd0);
                    end
                end
                if (prev_hold) begin
                    chk("hold_valid", 32'(inst_valid), 32'd1);
                    chk("hold_inst", inst, prev_inst);
                    chk("hold_inst_pc", inst_pc, prev_ipc);
                end
                if (prev_redir) chk("redirect_flush", 32'(inst_valid), 32'd0);
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        timeout("sb_empty");
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_inst_pc", inst_pc, e);
                        chk("sb_inst", inst, word(e));
                        exp_q.push_back(e + 32'd4);
                    end
                    consumed++;
                end
                if (redirect_valid && !boot_now) begin
                    exp_q.delete();
                    exp_q.push_back(redirect_pc);
                end
            end
            prev_hold  = !rst && inst_valid && !inst_ready && !redirect_valid;
            prev_inst  = inst;
            prev_ipc   = inst_pc;
            prev_redir = !rst && !boot_now && redirect_valid;
            prev_rst   = rst;
            npc_lat    = npc;
            hs_seen    = !rst && imem_req_valid && imem_req_ready;
            hs_addr    = imem_req_addr;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit found;
        int c0;
        rst = 1'b1;
        pc = 32'hFFFF_FFFC;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        consumed = 0; since_rst = 0; mem_pending = 0; mem_wait = 0; mem_addr = 0;
        npc_lat = 32'h0; hs_seen = 0; hs_addr = 0;
        rdy_pct = 100; ir_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
        a_npc = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8};
        a_iv  = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0};

        // Streaming with ideal memory: npc and first inst_valid timing.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("seq_npc", npc, a_npc[i]);
            chk("seq_inst_valid", 32'(inst_valid), a_iv[i]);
            tick();
        end
        repeat (10) tick();

        // Decode backpressure with 0x13 buffered at 0x8.
        do_reset();
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            if (inst_valid && inst_pc == 32'h8) found = 1;
        end
        if (!found) timeout("bp_find");
        inst_ready = 1'b0;
        ir_pct = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst", inst, 32'h13);
            chk("bp_inst_pc", inst_pc, 32'h8);
            chk("bp_no_req", 32'(imem_req_valid), 32'd0);
            tick();
        end
        ir_pct = 100;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_pc", inst_pc, 32'h8);
        repeat (6) tick();

        // Memory not ready for 5 cycles at pc 0x10.
        do_reset();
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            #1;
            if (pc == 32'h10 && imem_req_valid) found = 1;
        end
        if (!found) timeout("stall_find");
        imem_req_ready = 1'b0;
        rdy_pct = 0;
`ifdef IF_FETCH_PERF_CNT_EN
        stall_snap = perf_stall_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_npc", npc, 32'h10);
            chk("stall_addr", imem_req_addr, 32'h10);
            if (i < 4) tick();
        end
        rdy_pct = 100;
        tick();
`ifdef IF_FETCH_PERF_CNT_EN
        chk("perf_stall_delta", perf_stall_cnt - stall_snap, 32'd5);
`endif
        repeat (6) tick();

        // Redirect to 0x100 while waiting for 0xC.
        do_reset();
        lat_min = 2; lat_max = 2;
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            #1;
            if (pc == 32'hC && imem_req_valid && imem_req_ready) found = 1;
        end
        if (!found) timeout("rw_find");
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("rw_npc", npc, 32'h100);
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            @(negedge clk);
            if (inst_valid) begin
                found = 1;
                chk("rw_inst_pc", inst_pc, 32'h100);
                chk("rw_inst", inst, word(32'h100));
            end
        end
        if (!found) timeout("rw_valid");

        // Redirect in the same cycle as the handshake at 0x20.
        do_reset();
        lat_min = 1; lat_max = 1;
        found = 0;
        for (int n = 0; n < 80 && !found; n++) begin
            tick();
            #1;
            if (pc == 32'h20 && imem_req_valid && imem_req_ready) found = 1;
        end
        if (!found) timeout("rh_find");
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        chk("rh_npc", npc, 32'h200);
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1;
                chk("rh_next_addr", imem_req_addr, 32'h200);
            end
        end
        if (!found) timeout("rh_next_req");
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            @(negedge clk);
            if (inst_valid) begin
                found = 1;
                chk("rh_inst_pc", inst_pc, 32'h200);
            end
        end
        if (!found) timeout("rh_valid");

        // Reset in WAIT, stale response lands in BOOT.
        do_reset();
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            #1;
            if (imem_req_valid && imem_req_ready) found = 1;
        end
        if (!found) timeout("sr_find");
        tick();
        rst = 1'b1;
        pc = 32'hFFFF_FFFC;
        mem_pending = 0;
        tick();
        tick();
        rst = 1'b0;
        lat_min = 1; lat_max = 1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stale_boot_valid", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("stale_fetch_valid", 32'(inst_valid), 32'd0);
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            @(negedge clk);
            if (inst_valid) begin
                found = 1;
                chk("stale_restart_pc", inst_pc, 32'h0);
                chk("stale_restart_inst", inst, word(32'h0));
            end
        end
        if (!found) timeout("stale_valid");

        // Randomized traffic against the scoreboard, including wrap-around redirects.
        rdy_pct = 75; ir_pct = 70; redir_pct = 4; lat_min = 1; lat_max = 3;
        do_reset();
        c0 = consumed;
        repeat (3000) tick();
        chk("liveness", 32'((consumed - c0) >= 200), 32'd1);
        rdy_pct = 100; ir_pct = 100; redir_pct = 0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
